// File: rtl/md_seq.sv
// md_seq: multi-cycle multiply/divide unit owning the HI/LO register pair.
// Signed operands are reduced to magnitudes in PREP. RUN iterates once per
// cycle for 32 cycles: shift-add for multiply, restoring division for divide.
// FIX restores the result signs and commits HI/LO. mthi/mtlo write HI/LO
// directly from IDLE without leaving it.
module md_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        hilo_rd,
  output logic        ready,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [31:0] r_a;       // raw operand until PREP, then its magnitude
  logic [31:0] r_b;
  logic [63:0] r_acc;     // multiply: {partial, multiplier}; divide: {rem, quo}
  logic [5:0]  r_cnt;
  logic        r_neg_q;   // negate product / quotient in FIX
  logic        r_neg_r;   // negate remainder in FIX
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_is_div;
  logic        w_is_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic [33:0] w_div_trial;
  logic [63:0] w_div_next;
  logic [63:0] w_fix_prod;
  logic [31:0] w_fix_q;
  logic [31:0] w_fix_r;

  // Multi-cycle ops are the four with op[2]=0; reserved codes fall through.
  assign w_accept    = start && !cancel && !op[2];
  assign w_is_div    = r_op[1];
  assign w_is_signed = !r_op[0];

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state != S_IDLE);
  assign stall = busy && hilo_rd;
  assign hi    = r_hi;
  assign lo    = r_lo;

  // Operand magnitudes, one iteration step of each algorithm, sign fix-up.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_abs_a     = r_a;
    w_abs_b     = r_b;
    w_mul_sum   = 33'd0;
    w_mul_next  = r_acc;
    w_div_shift = 33'd0;
    w_div_trial = 34'd0;
    w_div_next  = r_acc;
    if (w_is_signed && r_a[31]) w_abs_a = -r_a;
    if (w_is_signed && r_b[31]) w_abs_b = -r_b;
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift right keeping the carry.
    w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
    w_mul_next = {w_mul_sum, r_acc[31:1]};
    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the difference only if it did not go negative.
    w_div_shift = {r_acc[63:32], r_acc[31]};
    w_div_trial = {1'b0, w_div_shift} - {2'b00, r_b};
    if (w_div_trial[33]) w_div_next = {w_div_shift[31:0], r_acc[30:0], 1'b0};
    else                 w_div_next = {w_div_trial[31:0], r_acc[30:0], 1'b1};
    w_fix_prod = r_neg_q ? -r_acc : r_acc;
    w_fix_q    = r_neg_q ? -r_acc[31:0]  : r_acc[31:0];
    w_fix_r    = r_neg_r ? -r_acc[63:32] : r_acc[63:32];
  end

  // Sequencer: IDLE -> PREP -> RUN (32 cycles) -> FIX -> IDLE; cancel aborts.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) r_state <= S_PREP;
        S_PREP:  r_state <= cancel ? S_IDLE : S_RUN;
        S_RUN: begin
          if (cancel)                r_state <= S_IDLE;
          else if (r_cnt == 6'd31)   r_state <= S_FIX;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand latch, magnitude/sign preparation and iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_acc   <= 64'd0;
      r_cnt   <= 6'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
          end
        end
        S_PREP: begin
          r_a     <= w_abs_a;
          r_b     <= w_abs_b;
          r_cnt   <= 6'd0;
          // A zero divisor leaves the all-ones quotient unsigned.
          r_neg_q <= w_is_signed && (r_a[31] ^ r_b[31]) &&
                     !(w_is_div && (r_b == 32'd0));
          r_neg_r <= w_is_signed && w_is_div && r_a[31];
          r_acc   <= w_is_div ? {32'd0, w_abs_a} : {32'd0, w_abs_b};
        end
        S_RUN: begin
          if (!cancel) begin
            r_cnt <= r_cnt + 6'd1;
            r_acc <= w_is_div ? w_div_next : w_mul_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO: written only at the FIX edge or by mthi/mtlo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (r_state == S_FIX) begin
      if (!cancel) begin
        if (w_is_div) begin
          r_hi <= w_fix_r;
          r_lo <= w_fix_q;
        end else begin
          r_hi <= w_fix_prod[63:32];
          r_lo <= w_fix_prod[31:0];
        end
      end
    end else if (r_state == S_IDLE && start && !cancel) begin
      if (op == OP_MTHI) r_hi <= a;
      if (op == OP_MTLO) r_lo <= a;
    end
  end

endmodule

// File: tb/tb_md_seq.sv
// Testbench for md_seq: scenario tasks with a queue of expected {hi,lo}
// results produced by a behavioural arithmetic model.
module tb_md_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        hilo_rd;
  logic        ready;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hilo_rd(hilo_rd), .ready(ready), .busy(busy),
    .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} computed with native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] f_op,
                                        input logic [31:0] fa,
                                        input logic [31:0] fb);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sa = $signed(fa);
    sb = $signed(fb);
    case (f_op)
      3'b000: return sa * sb;
      3'b001: return {32'd0, fa} * {32'd0, fb};
      3'b010: begin
        if (fb == 32'd0) return {fa, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'b011: begin
        if (fb == 32'd0) return {fa, 32'hFFFFFFFF};
        return {fa % fb, fa / fb};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Present one start for one edge; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] t_op, input logic [31:0] ta,
                       input logic [31:0] tb, input bit push);
    @(negedge clk);
    start = 1'b1;
    op    = t_op;
    a     = ta;
    b     = tb;
    if (push) sb_q.push_back(model(t_op, ta, tb));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  // Count busy cycles (sampled on negedges) with a bounded budget.
  task automatic wait_done(output int n);
    n = 1;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n--;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    cancel = 1'b0; hilo_rd = 1'b1;
    #12;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b busy=%b stall=%b, want 1 0 0", ready, busy, stall);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h, want 0 0", hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hilo_rd = 1'b0;
  endtask

  // Runs a table of operations one after another and scores each result.
  task automatic run_table(input string name, input logic [2:0] t_op[],
                           input logic [31:0] ta[], input logic [31:0] tb[]);
    int n;
    logic [63:0] e;
    foreach (t_op[i]) begin
      issue(t_op[i], ta[i], tb[i], 1'b1);
      wait_done(n);
      checks++;
      if (n !== 34) begin
        errors++;
        $display("FAIL %s_latency[%0d]: busy cycles=%0d, want 34", name, i, n);
      end
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s_queue[%0d]: scoreboard empty", name, i);
      end else begin
        e = sb_q.pop_front();
        if (hi !== e[63:32] || lo !== e[31:0] || ready !== 1'b1) begin
          errors++;
          $display("FAIL %s_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h ready=%b, want hi=%h lo=%h ready=1",
                   name, i, t_op[i], ta[i], tb[i], hi, lo, ready, e[63:32], e[31:0]);
        end
        exp_hi = e[63:32];
        exp_lo = e[31:0];
      end
    end
  endtask

  task automatic test_mult;
    logic [2:0]  o[] = '{3'd0, 3'd1, 3'd0, 3'd1};
    logic [31:0] x[] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] y[] = '{32'd3, 32'd3, 32'h80000000, 32'hFFFFFFFF};
    run_table("mult", o, x, y);
  endtask

  task automatic test_div;
    logic [2:0]  o[] = '{3'd2, 3'd3, 3'd2, 3'd2};
    logic [31:0] x[] = '{32'hFFFFFFF9, 32'd100, 32'd7, 32'h7FFFFFFF};
    logic [31:0] y[] = '{32'd2, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF0};
    run_table("div", o, x, y);
  endtask

  task automatic test_boundary;
    logic [2:0]  o[] = '{3'd3, 3'd2, 3'd2, 3'd3};
    logic [31:0] x[] = '{32'h12345678, 32'h80000000, 32'hFFFFFFFB, 32'd5};
    logic [31:0] y[] = '{32'd0, 32'hFFFFFFFF, 32'd0, 32'd9};
    run_table("bound", o, x, y);
  endtask

  task automatic test_back_to_back;
    logic [2:0]  o[] = new[6];
    logic [31:0] x[] = new[6];
    logic [31:0] y[] = new[6];
    foreach (o[i]) begin
      o[i] = 3'(i % 4);
      x[i] = $urandom;
      y[i] = (i == 5) ? 32'd1 : $urandom;
    end
    run_table("b2b", o, x, y);
  endtask

  task automatic test_stall_ignore;
    int cycle;
    logic [63:0] e;
    issue(3'd0, 32'h00001234, 32'hFFFF5678, 1'b1);
    cycle = 1;
    while (busy === 1'b1 && cycle < 100) begin
      start = (cycle == 5);
      if (cycle == 5) begin
        op = 3'd3; a = 32'd99; b = 32'd3;
      end
      hilo_rd = (cycle >= 10);
      #1;
      if (cycle >= 10) begin
        checks++;
        if (stall !== 1'b1) begin
          errors++;
          $display("FAIL stall_busy[%0d]: stall=%b, want 1", cycle, stall);
        end
      end
      @(negedge clk);
      cycle++;
    end
    start = 1'b0;
    checks++;
    if (cycle !== 35) begin
      errors++;
      $display("FAIL stall_latency: busy cycles=%0d, want 34", cycle - 1);
    end
    checks++;
    if (stall !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: stall=%b ready=%b, want 0 1", stall, ready);
    end
    hilo_rd = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (hi !== e[63:32] || lo !== e[31:0]) begin
      errors++;
      $display("FAIL ignore_start: hi=%h lo=%h, want hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
    end
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  task automatic test_cancel;
    // mthi preset
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    exp_hi = 32'd5;
    checks++;
    if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b ready=%b, want hi=%h lo=%h busy=0 ready=1",
               hi, lo, busy, ready, exp_hi, exp_lo);
    end
    // div cancelled in its 20th busy cycle
    issue(3'd2, 32'd1000, 32'd7, 1'b0);
    for (int c = 1; c < 20; c++) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL cancel_run: ready=%b busy=%b hi=%h lo=%h, want 1 0 hi=%h lo=%h",
               ready, busy, hi, lo, exp_hi, exp_lo);
    end
    // mtlo suppressed by cancel
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'd77; cancel = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; cancel = 1'b0; end
    checks++;
    if (lo !== exp_lo || ready !== 1'b1) begin
      errors++;
      $display("FAIL cancel_mtlo: lo=%h ready=%b, want lo=%h ready=1", lo, ready, exp_lo);
    end
    // reserved op is a no-op
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'hABCD;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (ready !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL reserved_op: ready=%b hi=%h lo=%h, want 1 hi=%h lo=%h",
               ready, hi, lo, exp_hi, exp_lo);
    end
    // mtlo accepted
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'h0BADF00D;
    @(posedge clk);
    #1 start = 1'b0;
    exp_lo = 32'h0BADF00D;
    checks++;
    if (lo !== exp_lo || hi !== exp_hi) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h, want hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [63:0] e;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    for (int c = 1; c < 15; c++) @(negedge clk);
    hilo_rd = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || ready !== 1'b1 || busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: hi=%h lo=%h ready=%b busy=%b stall=%b, want 0 0 1 0 0",
               hi, lo, ready, busy, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hilo_rd = 1'b0;
    issue(3'd1, 32'd6, 32'd7, 1'b1);
    wait_done(n);
    e = sb_q.pop_front();
    checks++;
    if (n !== 34 || hi !== e[63:32] || lo !== e[31:0]) begin
      errors++;
      $display("FAIL after_reset_multu: cycles=%0d hi=%h lo=%h, want 34 hi=%h lo=%h",
               n, hi, lo, e[63:32], e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_boundary();
    test_back_to_back();
    test_stall_ignore();
    test_cancel();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  request qualifier, sampled only when ready=1.
REQ-004 SHALL have ports: op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved.
REQ-005 SHALL have ports: a, b  in  32 each  operands; a is dividend/multiplicand/mthi-mtlo source.
REQ-006 SHALL have ports: cancel  in  1  pipeline flush; aborts the operation in flight.
REQ-007 SHALL have ports: hilo_rd  in  1  decode stage reads HI or LO this cycle.
REQ-008 SHALL have ports: ready  out  1  idle and able to accept start.
REQ-009 SHALL have ports: busy  out  1  multi-cycle operation in flight.
REQ-010 SHALL have ports: stall  out  1  equals busy AND hilo_rd, combinational.
REQ-011 SHALL have ports: hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL implement states IDLE, PREP, RUN, FIX; ready=1 only in IDLE; busy=1 in PREP, RUN, FIX.
REQ-013 SHALL, in IDLE with start=1, cancel=0, op in {mult,multu,div,divu}, latch a, b and op, then enter PREP.
REQ-014 SHALL, in IDLE with start=1, cancel=0, op=mthi (mtlo), write a into hi (lo) at that edge, stay in IDLE, never raise busy.
REQ-015 SHALL treat reserved op with start as a no-op: no state change, hi/lo unchanged.
REQ-016 SHALL ignore start while busy=1; the latched operation is unaffected.
REQ-017 SHALL in PREP take absolute values of signed operands (op 000/010), record result signs, load a 6-bit iteration counter with 0, go to RUN.
REQ-018 SHALL in RUN perform one iteration per cycle for exactly 32 cycles: shift-add for multiply, restoring shift-subtract for divide; counter increments, RUN->FIX after iteration 31.
REQ-019 SHALL in FIX apply sign correction (two's complement of 64-bit product; quotient negated if signs differ; remainder takes sign of a), write hi/lo at the FIX edge, go to IDLE.
REQ-020 SHALL give fixed latency: start accepted at edge E0, busy high E0+1..E0+34, new hi/lo visible after edge E0+34, ready high again same cycle.
REQ-021 SHALL place product[63:32] in hi and product[31:0] in lo; remainder in hi and quotient in lo for divide.
REQ-022 SHALL on divide by zero (b=0) keep the 34-cycle latency and produce lo=32'hFFFFFFFF, hi=a, no exception.
REQ-023 SHALL on signed 32'h80000000 / 32'hFFFFFFFF produce lo=32'h80000000, hi=0.
REQ-024 SHALL on cancel=1 in PREP/RUN/FIX return to IDLE at the next edge with hi/lo unchanged; cancel with start in IDLE suppresses the start, including mthi/mtlo.
REQ-025 SHALL hold hi/lo stable in every cycle except the FIX write edge and mthi/mtlo edges.

Reset
REQ-026 SHALL on rst_n=0 asynchronously force IDLE, hi=0, lo=0, counter=0, ready=1, busy=0, stall=0.
REQ-027 SHALL discard an operation in flight when reset asserts mid-operation; first start after rst_n deassert is accepted normally.

Verification
REQ-028 SHALL cover: mult a=32'hFFFFFFFE (-2), b=3 -> after 34 busy cycles hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; multu same operands -> hi=2, lo=32'hFFFFFFFA.
REQ-029 SHALL cover: div a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); divu a=100, b=7 -> lo=14, hi=2.
REQ-030 SHALL cover: divu a=32'h12345678, b=0 -> lo=32'hFFFFFFFF, hi=32'h12345678; div 32'h80000000 by -1 -> lo=32'h80000000, hi=0.
REQ-031 SHALL cover: start mult, hilo_rd=1 at cycle 10 -> stall=1 while busy, stall=0 in the cycle ready returns; second start at cycle 5 ignored.
REQ-032 SHALL cover: hi=5 preset via mthi, start div, cancel at cycle 20 -> IDLE next edge, hi=5 unchanged; mtlo with cancel=1 -> lo unchanged.
REQ-033 SHALL cover: rst_n pulsed low mid-RUN -> hi=lo=0, ready=1 immediately; following multu 6x7 -> lo=42, hi=0.
